dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access at a time: IDLE grants, ISSUE drives memory, WAIT covers read latency.
module dmem_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_we,
  input  logic        r1_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic        mem_wren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_q,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [1:0] LAST = 2'(READ_LAT - 1);

  state_t      state, state_nxt;
  logic        ptr;
  logic        owner;
  logic        cur_we;
  logic [1:0]  cnt;
  logic        win;
  logic        grant;
  logic        done;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    win       = (r0_req && r1_req) ? ptr : r1_req;
    sel_we    = win ? r1_we    : r0_we;
    sel_addr  = win ? r1_addr  : r0_addr;
    sel_data  = win ? r1_wdata : r0_wdata;
    case (state)
      IDLE: begin
        // reset gating keeps gnt low while state is forced to IDLE
        if ((r0_req || r1_req) && !reset) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = cur_we ? IDLE : WAIT;
      WAIT: begin
        if (cnt == LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    r0_gnt = grant && !win;
    r1_gnt = grant && win;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      owner     <= 1'b0;
      cur_we    <= 1'b0;
      cnt       <= '0;
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      mem_wren  <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (grant) begin
        owner    <= win;
        ptr      <= ~win;
        cur_we   <= sel_we;
        mem_wren <= sel_we;
        mem_addr <= sel_addr;
        mem_data <= sel_data;
      end
      if (state == WAIT) cnt <= done ? '0 : cnt + 2'd1;
      if (done) begin
        if (owner) begin
          r1_rdata  <= mem_q;
          r1_rvalid <= 1'b1;
        end else begin
          r0_rdata  <= mem_q;
          r0_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level model predicts grants,
// memory effects and read results; a negedge monitor retires them.
module tb_dmem_arbiter;

  localparam int unsigned LAT = 3;

  typedef struct {
    int          who;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          t;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_wren, busy;
  logic [31:0] r0_rdata, r1_rdata, mem_addr, mem_data, mem_q;

  logic [31:0] dmem [0:31];
  logic [31:0] pipe [0:2];

  int          errors = 0;
  int          checks = 0;
  txn_t        sb[$];
  int          cyc = 0;
  int          busy_left = 0;
  bit          ptr = 1'b0;
  logic [31:0] mem_m [0:31];
  logic [31:0] last_rd [2];
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.READ_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r1_req(req[1]),
    .r0_we(we[0]), .r1_we(we[1]),
    .r0_addr(addr[0]), .r1_addr(addr[1]),
    .r0_wdata(wdata[0]), .r1_wdata(wdata[1]),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q), .busy(busy)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory device: write on mem_wren, read data emerges LAT cycles after address.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) dmem[i] <= init_word(i);
    end else if (mem_wren) begin
      dmem[mem_addr[4:0]] <= mem_data;
    end
    pipe[0] <= dmem[mem_addr[4:0]];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign mem_q = pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl"}, 32'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_wren, busy}), 32'd0);
    check({tag, "_data"}, r0_rdata | r1_rdata | mem_addr | mem_data, 32'd0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        check_zero_outputs("reset");
        sb.delete();
        busy_left = 0;
        ptr = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        m_addr = '0;
        m_data = '0;
        for (int i = 0; i < 32; i++) mem_m[i] = init_word(i);
      end else begin
        int w;
        txn_t t;
        logic [1:0] exp_gnt;
        cyc++;
        if (mem_wren) begin
          if (sb.size() == 0 || !sb[0].we) begin
            check("unexpected_wren", 32'(mem_wren), 32'd0);
          end else begin
            check("wr_time", 32'(cyc), 32'(sb[0].t + 1));
            check("wr_addr", mem_addr, sb[0].addr);
            check("wr_data", mem_data, sb[0].wdata);
            void'(sb.pop_front());
          end
        end
        check("rvalid_both", 32'(r0_rvalid & r1_rvalid), 32'd0);
        if (r0_rvalid || r1_rvalid) begin
          if (sb.size() == 0 || sb[0].we) begin
            check("unexpected_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
          end else begin
            check("rd_who", 32'(r1_rvalid), 32'(sb[0].who));
            check("rd_time", 32'(cyc), 32'(sb[0].t + 2 + int'(LAT)));
            check("rd_data", r1_rvalid ? r1_rdata : r0_rdata, sb[0].rdata);
            last_rd[sb[0].who] = sb[0].rdata;
            void'(sb.pop_front());
          end
        end
        if (sb.size() > 0 && cyc > sb[0].t + 2 + int'(LAT)) begin
          check("response_timeout", 32'(cyc), 32'(sb[0].t + 2 + int'(LAT)));
          void'(sb.pop_front());
        end
        check("r0_rdata_hold", r0_rdata, last_rd[0]);
        check("r1_rdata_hold", r1_rdata, last_rd[1]);
        check("mem_addr_hold", mem_addr, m_addr);
        check("mem_data_hold", mem_data, m_data);
        check("busy", 32'(busy), 32'(busy_left > 0));
        exp_gnt = 2'b00;
        if (busy_left > 0) begin
          busy_left--;
        end else if (req[0] || req[1]) begin
          w = (req[0] && req[1]) ? int'(ptr) : (req[1] ? 1 : 0);
          exp_gnt[w] = 1'b1;
          t.who   = w;
          t.we    = we[w];
          t.addr  = addr[w];
          t.wdata = wdata[w];
          t.rdata = we[w] ? '0 : mem_m[addr[w][4:0]];
          t.t     = cyc;
          sb.push_back(t);
          if (we[w]) mem_m[addr[w][4:0]] = wdata[w];
          ptr       = (w == 0);
          busy_left = we[w] ? 1 : 1 + int'(LAT);
          m_addr    = addr[w];
          m_data    = wdata[w];
        end
        check("gnt", 32'({r1_gnt, r0_gnt}), 32'(exp_gnt));
      end
    end
  end

  // Holds a request until granted; returns at posedge+1 after the grant edge.
  task automatic do_req(input int who, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit granted = 1'b0;
    req[who]   = 1'b1;
    we[who]    = w;
    addr[who]  = a;
    wdata[who] = d;
    for (int i = 0; i < 300 && !granted; i++) begin
      @(negedge clk);
      granted = (who == 0) ? r0_gnt : r1_gnt;
    end
    check("gnt_wait", 32'(granted), 32'd1);
    @(posedge clk);
    #1;
    req[who] = 1'b0;
  endtask

  task automatic run_random(input int who, input int n);
    for (int k = 0; k < n; k++) begin
      int gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
      do_req(who, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom());
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy_left == 0 && !busy) break;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // both request at once after reset: r0 write wins, r1 read returns its data
    fork
      do_req(0, 1'b1, 32'h0A, 32'hDEAD_BEEF);
      do_req(1, 1'b0, 32'h0A, 32'h0);
    join
    wait_idle();

    // continuous contention must alternate
    fork
      repeat (4) do_req(0, 1'b0, 32'h00, 32'h0);
      repeat (4) do_req(1, 1'b0, 32'h03, 32'h0);
    join
    wait_idle();

    do_req(0, 1'b0, 32'h10, 32'h0);
    wait_idle();

    fork
      run_random(0, 40);
      run_random(1, 40);
    join
    wait_idle();

    // abort a read in WAIT, then a fresh read must complete
    do_req(0, 1'b0, 32'h05, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_req(0, 1'b0, 32'h05, 32'h0);
    wait_idle();
    repeat (4) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
